// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST sequencer: FSM encoding, LFSR/MISR polynomial,
// MISR feedback taps and the LFSR step helper.
package alu_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

   localparam int MISR_TAP_3 = 31;
   localparam int MISR_TAP_2 = 21;
   localparam int MISR_TAP_1 = 1;
   localparam int MISR_TAP_0 = 0;

   // Galois step shared by both operand generators.
   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return {x[30:0], 1'b0} ^ (x[31] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [31:0] misr_shift(input logic [31:0] s);
      return {s[30:0], s[MISR_TAP_3] ^ s[MISR_TAP_2] ^ s[MISR_TAP_1] ^ s[MISR_TAP_0]};
   endfunction

   // An all-zero seed would lock the generator, so it is promoted to 1.
   function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
      return (s == 32'h0) ? 32'h0000_0001 : s;
   endfunction

endpackage

// File: rtl/alu_bist_lfsr32.sv
// 32-bit Galois LFSR operand generator; reset and load both reload the seed.
module alu_bist_lfsr32
   import alu_bist_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] value
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || load)
         value <= seed;
      else if (step)
         value <= lfsr_next(value);
   end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: LFSR operands, full aluc sweep per pair, MISR compaction.
// Optional zero-flag consistency check enabled by defining ALU_BIST_ZCHECK_EN.
module alu_bist
   import alu_bist_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 8,
   parameter logic [31:0] A_SEED      = 32'h1234_5678,
   parameter logic [31:0] B_SEED      = 32'h8765_4321,
   parameter logic [31:0] MISR_SEED   = 32'hFFFF_FFFF,
   parameter logic [15:0] OP_MASK     = 16'hFFFF,
   parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
`ifdef ALU_BIST_ZCHECK_EN
   output logic        zero_err,
`endif
   output logic        pass,
   output logic [31:0] signature,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_aluc,
   input  logic [31:0] alu_r,
   input  logic        alu_z
);

   localparam logic [31:0] A_INIT    = nonzero_seed(A_SEED);
   localparam logic [31:0] B_INIT    = nonzero_seed(B_SEED);
   localparam logic [31:0] MISR_INIT = nonzero_seed(MISR_SEED);
   localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);

   state_t      state, state_next;
   logic [15:0] vec_cnt;
   logic        load, run, wrap, last;
   logic [31:0] sig_next;
   logic        pass_ok;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (last)  state_next = ST_DONE;
         ST_DONE:            state_next = ST_IDLE;
         default:            state_next = ST_IDLE;
      endcase
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      load = 1'b0;
      run  = 1'b0;
      unique case (state)
         ST_IDLE: load = start;
         ST_RUN: begin
            busy = 1'b1;
            run  = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
      wrap = run && (alu_aluc == 4'hF);
      last = wrap && (vec_cnt == LAST_VEC);
   end

   alu_bist_lfsr32 u_lfsr_a (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (wrap),
      .seed  (A_INIT),
      .value (alu_a)
   );

   alu_bist_lfsr32 u_lfsr_b (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (wrap),
      .seed  (B_INIT),
      .value (alu_b)
   );

   // The zero flag is folded into bit 0 so a wrong z alone still perturbs the signature.
   always_comb begin
      sig_next = signature;
      if (OP_MASK[alu_aluc])
         sig_next = misr_shift(signature) ^ {alu_r[31:1], alu_r[0] ^ alu_z};
   end

`ifdef ALU_BIST_ZCHECK_EN
   logic zerr_next;

   assign zerr_next = zero_err | (alu_z != (alu_r == 32'h0));
   assign pass_ok   = (sig_next == GOLDEN_SIG) && !zerr_next;

   always_ff @(posedge clk) begin
      if (reset || load)
         zero_err <= 1'b0;
      else if (run)
         zero_err <= zerr_next;
   end
`else
   assign pass_ok = (sig_next == GOLDEN_SIG);
`endif

   always_ff @(posedge clk) begin
      if (reset || load) begin
         alu_aluc  <= 4'h0;
         vec_cnt   <= 16'h0;
         signature <= MISR_INIT;
         pass      <= 1'b0;
      end else if (run) begin
         signature <= sig_next;
         alu_aluc  <= alu_aluc + 4'h1;
         if (wrap)
            vec_cnt <= vec_cnt + 16'h1;
         if (last)
            pass <= pass_ok;
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: two instances (4-vector full mask, 1-vector op-0 mask)
// driven by a stub ALU and checked every cycle against a cycle-index reference model.
module tb_alu_bist;

   localparam logic [31:0] POLY   = 32'h0040_0007;
   localparam logic [31:0] SEED_A = 32'h1234_5678;
   localparam logic [31:0] SEED_B = 32'h8765_4321;
   localparam logic [31:0] SEED_S = 32'hFFFF_FFFF;

   localparam int MODE_ADD    = 0;
   localparam int MODE_MASKED = 1;
   localparam int MODE_RAND   = 2;

`ifdef ALU_BIST_ZCHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   // Golden signature of an r=a+b, z=(r==0) ALU over n operand pairs.
   function automatic logic [31:0] golden_add(input int n);
      logic [31:0] s, a, b, r;
      s = SEED_S;
      a = SEED_A;
      b = SEED_B;
      for (int v = 0; v < n; v++) begin
         for (int op = 0; op < 16; op++) begin
            r = a + b;
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {r[31:1], r[0] ^ (r == 32'h0)};
         end
         a = {a[30:0], 1'b0} ^ (a[31] ? POLY : 32'h0);
         b = {b[30:0], 1'b0} ^ (b[31] ? POLY : 32'h0);
      end
      return s;
   endfunction

   localparam logic [31:0] GOLD0 = golden_add(4);
   localparam logic [31:0] GOLD1 = 32'h6666_6667;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
   } alu_out_t;

   function automatic int nv(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic logic [15:0] op_mask(input int i);
      return (i == 0) ? 16'hFFFF : 16'h0001;
   endfunction

   function automatic logic [31:0] gold(input int i);
      return (i == 0) ? GOLD0 : GOLD1;
   endfunction

   function automatic logic [31:0] step(input logic [31:0] x);
      return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);
   endfunction

   function automatic logic [31:0] absorb(input logic [31:0] s, input logic [31:0] r, input logic z);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r ^ {31'h0, z};
   endfunction

   function automatic alu_out_t alu_stub(input int mode, input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic [31:0] rr, input logic rz,
                                         input logic flip, input logic zbad);
      alu_out_t o;
      o.r = a + b;
      if (mode == MODE_MASKED && op != 4'h0)
         o.r = 32'hDEAD_BEEF;
      o.z = (o.r == 32'h0);
      if (mode == MODE_RAND) begin
         o.r = rr;
         o.z = rz;
      end
      o.r = o.r ^ (flip ? 32'h0000_0020 : 32'h0);
      if (zbad) begin
         o.r = 32'h0;
         o.z = 1'b0;
      end
      return o;
   endfunction

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  start_v = 2'b00;
   logic [1:0]  flip_v = 2'b00;
   logic [1:0]  zbad_v = 2'b00;
   int          mode_v [2] = '{MODE_ADD, MODE_MASKED};
   logic [31:0] rnd_r [2] = '{32'h0, 32'h0};
   logic [1:0]  rnd_z = 2'b00;

   logic [1:0]  busy_v, done_v, pass_v, zerr_v;
   logic [31:0] sig_d [2];
   logic [31:0] a_d [2];
   logic [31:0] b_d [2];
   logic [3:0]  op_d [2];
   logic [31:0] r_d [2];
   logic [1:0]  z_d;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_bist #(
      .NUM_VECTORS (4),
      .OP_MASK     (16'hFFFF),
      .GOLDEN_SIG  (GOLD0)
   ) u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .start     (start_v[0]),
      .busy      (busy_v[0]),
      .done      (done_v[0]),
`ifdef ALU_BIST_ZCHECK_EN
      .zero_err  (zerr_v[0]),
`endif
      .pass      (pass_v[0]),
      .signature (sig_d[0]),
      .alu_a     (a_d[0]),
      .alu_b     (b_d[0]),
      .alu_aluc  (op_d[0]),
      .alu_r     (r_d[0]),
      .alu_z     (z_d[0])
   );

   alu_bist #(
      .NUM_VECTORS (1),
      .OP_MASK     (16'h0001),
      .GOLDEN_SIG  (GOLD1)
   ) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start_v[1]),
      .busy      (busy_v[1]),
      .done      (done_v[1]),
`ifdef ALU_BIST_ZCHECK_EN
      .zero_err  (zerr_v[1]),
`endif
      .pass      (pass_v[1]),
      .signature (sig_d[1]),
      .alu_a     (a_d[1]),
      .alu_b     (b_d[1]),
      .alu_aluc  (op_d[1]),
      .alu_r     (r_d[1]),
      .alu_z     (z_d[1])
   );

`ifndef ALU_BIST_ZCHECK_EN
   assign zerr_v = 2'b00;
`endif

   always_comb begin
      alu_out_t o;
      for (int i = 0; i < 2; i++) begin
         o = alu_stub(mode_v[i], a_d[i], b_d[i], op_d[i], rnd_r[i], rnd_z[i], flip_v[i], zbad_v[i]);
         r_d[i] = o.r;
         z_d[i] = o.z;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: k = cycle index within a run (-1 idle, 16N = done cycle).
   int          k [2] = '{-1, -1};
   logic [31:0] e_sig [2] = '{SEED_S, SEED_S};
   logic [31:0] e_a [2] = '{SEED_A, SEED_A};
   logic [31:0] e_b [2] = '{SEED_B, SEED_B};
   logic [1:0]  e_pass = 2'b00;
   logic [1:0]  e_zerr = 2'b00;

   always @(negedge clk) begin
      int       n16;
      logic [3:0] eop;
      alu_out_t o;
      for (int i = 0; i < 2; i++) begin
         n16 = 16 * nv(i);
         eop = (k[i] >= 0 && k[i] < n16) ? 4'(k[i] % 16) : 4'h0;
         check($sformatf("u%0d.busy", i), 32'(busy_v[i]), 32'(k[i] >= 0 && k[i] < n16));
         check($sformatf("u%0d.done", i), 32'(done_v[i]), 32'(k[i] == n16));
         check($sformatf("u%0d.pass", i), 32'(pass_v[i]), 32'(e_pass[i]));
         check($sformatf("u%0d.signature", i), sig_d[i], e_sig[i]);
         check($sformatf("u%0d.alu_a", i), a_d[i], e_a[i]);
         check($sformatf("u%0d.alu_b", i), b_d[i], e_b[i]);
         check($sformatf("u%0d.alu_aluc", i), 32'(op_d[i]), 32'(eop));
         if (ZC)
            check($sformatf("u%0d.zero_err", i), 32'(zerr_v[i]), 32'(e_zerr[i]));

         if (reset) begin
            k[i] = -1;
            e_sig[i] = SEED_S;
            e_a[i] = SEED_A;
            e_b[i] = SEED_B;
            e_pass[i] = 1'b0;
            e_zerr[i] = 1'b0;
         end else if (k[i] < 0) begin
            if (start_v[i]) begin
               k[i] = 0;
               e_sig[i] = SEED_S;
               e_a[i] = SEED_A;
               e_b[i] = SEED_B;
               e_pass[i] = 1'b0;
               e_zerr[i] = 1'b0;
            end
         end else if (k[i] < n16) begin
            o = alu_stub(mode_v[i], e_a[i], e_b[i], eop, rnd_r[i], rnd_z[i], flip_v[i], zbad_v[i]);
            if (op_mask(i)[eop])
               e_sig[i] = absorb(e_sig[i], o.r, o.z);
            if (o.z != (o.r == 32'h0))
               e_zerr[i] = 1'b1;
            if (eop == 4'hF) begin
               e_a[i] = step(e_a[i]);
               e_b[i] = step(e_b[i]);
            end
            if (k[i] == n16 - 1)
               e_pass[i] = (e_sig[i] == gold(i)) && !(ZC && e_zerr[i]);
            k[i] = k[i] + 1;
         end else begin
            k[i] = -1;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_r[0] = $urandom;
         rnd_r[1] = $urandom;
         rnd_z = 2'($urandom_range(3));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on instance i and follow the run until done or the cycle budget expires.
   task automatic run(input int i, input bit pin, input int flip_at, input int zbad_vec,
                      input int reset_at, output int lat, output int nbusy, output bit got_done);
      int budget;
      budget = 16 * nv(i) + 4;
      lat = 0;
      nbusy = 0;
      got_done = 1'b0;
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         flip_v[i] = (c - 1 == flip_at);
         zbad_v[i] = (zbad_vec >= 0) && ((c - 1) / 16 == zbad_vec);
         reset = (c - 1 == reset_at);
         @(negedge clk);
         lat = c;
         if (busy_v[i]) nbusy++;
         if (pin && c == 2)
            check("first_absorb_sig", sig_d[i], 32'h6666_6667);
         if (pin && c == 17)
            check("alu_b_after_wrap", b_d[i], 32'h0E8A_8645);
         if (reset_at >= 0 && c - 1 == reset_at + 1) begin
            check("abort.busy", 32'(busy_v[i]), 32'h0);
            check("abort.signature", sig_d[i], SEED_S);
            check("abort.alu_a", a_d[i], SEED_A);
         end
         if (done_v[i]) begin
            got_done = 1'b1;
            break;
         end
         tick();
      end
      flip_v[i] = 1'b0;
      zbad_v[i] = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int lat, nbusy;
      bit got;

      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset.signature", sig_d[0], 32'hFFFF_FFFF);
      check("reset.alu_a", a_d[0], 32'h1234_5678);
      check("reset.alu_b", b_d[0], 32'h8765_4321);
      check("reset.alu_aluc", 32'(op_d[0]), 32'h0);
      repeat (10) tick();

      // One-vector sweep with op-0-only mask and DEADBEEF on masked opcodes.
      run(1, 1'b0, -1, -1, -1, lat, nbusy, got);
      check("u1.done_seen", 32'(got), 32'h1);
      check("u1.done_latency", 32'(lat), 32'd17);
      check("u1.busy_cycles", 32'(nbusy), 32'd16);
      check("u1.pass", 32'(pass_v[1]), 32'h1);

      // Four-vector add run against the precomputed golden signature.
      run(0, 1'b1, -1, -1, -1, lat, nbusy, got);
      check("u0.done_latency", 32'(lat), 32'd65);
      check("u0.busy_cycles", 32'(nbusy), 32'd64);
      check("u0.pass_clean", 32'(pass_v[0]), 32'h1);
      check("u0.final_sig", sig_d[0], GOLD0);

      run(0, 1'b0, 20, -1, -1, lat, nbusy, got);
      check("u0.pass_flipped", 32'(pass_v[0]), 32'h0);

      mode_v[0] = MODE_RAND;
      mode_v[1] = MODE_RAND;
      for (int n = 0; n < 3; n++) begin
         run(0, 1'b0, -1, -1, -1, lat, nbusy, got);
         check("u0.rand_done", 32'(got), 32'h1);
         run(1, 1'b0, -1, -1, -1, lat, nbusy, got);
         check("u1.rand_done", 32'(got), 32'h1);
      end
      mode_v[0] = MODE_ADD;
      mode_v[1] = MODE_MASKED;

      // Held start: no mid-run restart, then a fresh run after DONE.
      start_v[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 80 && !got; c++) begin
         @(negedge clk);
         got = done_v[0];
         tick();
      end
      check("held.first_done", 32'(got), 32'h1);
      @(negedge clk);
      check("held.idle_gap", 32'(busy_v[0]), 32'h0);
      tick();
      @(negedge clk);
      check("held.restart", 32'(busy_v[0]), 32'h1);
      start_v[0] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 80 && !got; c++) begin
         tick();
         @(negedge clk);
         got = done_v[0];
      end
      check("held.second_done", 32'(got), 32'h1);
      check("held.second_pass", 32'(pass_v[0]), 32'h1);
      tick();

      run(0, 1'b0, -1, -1, 7, lat, nbusy, got);
      check("abort.no_done", 32'(got), 32'h0);

      // One vector returns r=0, z=0.
      run(0, 1'b0, -1, 1, -1, lat, nbusy, got);
      check("zbad.pass", 32'(pass_v[0]), 32'h0);
      if (ZC)
         check("zbad.zero_err", 32'(zerr_v[0]), 32'h1);
      run(0, 1'b0, -1, -1, -1, lat, nbusy, got);
      check("after_zbad.pass", 32'(pass_v[0]), 32'h1);
      if (ZC)
         check("after_zbad.zero_err", 32'(zerr_v[0]), 32'h0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end

endmodule
